decodificador: RTL
==================

DECODIFICADOR -- requirements
Module: Decodificador

Interface
REQ-001 SHALL: parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL: reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 SHALL: S0, S1, S2, S3  input  1 each  received 4-bit code word; S0 is the MSB.
REQ-005 SHALL: ready  input  1  code word on S0..S3 is valid this cycle.
REQ-006 SHALL: ack  input  1  consumer accepts the head word this cycle.
REQ-007 SHALL: A, B, C, D  output  1 each  decoded head data word; A is the MSB.
REQ-008 SHALL: valid  output  1  A..D carry a decoded word.
REQ-009 SHALL: full  output  1  FIFO holds DEPTH words.
REQ-010 SHALL: overflow  output  1  sticky; a word was dropped.

Function
REQ-011 SHALL: decode map {S0S1S2S3} -> {ABCD}, hex code->data: 0->3, 1->4, 2->B, 3->9, 4->6, 5->0, 6->E, 7->8, 8->D, 9->2, A->F, B->7, C->1, D->A, E->C, F->5 (exact inverse of the team's 4-bit encoder; bijective, no invalid codes).
REQ-012 SHALL: decode combinationally; on a rising edge with ready=1 and the word accepted, write the decoded word at the FIFO tail.
REQ-013 SHALL: latency 1 clock -- word pushed into an empty FIFO appears on A..D with valid=1 the cycle after ready.
REQ-014 SHALL: valid=1 iff occupancy>0; full=1 iff occupancy=DEPTH.
REQ-015 SHALL: A..D show the head entry when valid=1, else 0000.
REQ-016 SHALL: pop on rising edge with ack=1 and valid=1; ack with valid=0 is ignored with no side effect.
REQ-017 SHALL: occupancy FSM EMPTY -> PARTIAL (push) -> FULL (push at DEPTH-1); FULL -> PARTIAL (pop only); PARTIAL -> EMPTY (pop at 1).
REQ-018 SHALL: ready=1, ack=1, valid=1 in same cycle -> push and pop together; occupancy unchanged, also when full.
REQ-019 SHALL: ready=1, full=1, ack=0 -> incoming word dropped, FIFO contents unchanged, overflow set next cycle.
REQ-020 SHALL: overflow stays 1 until reset; it does not block further pushes once space exists.
REQ-021 SHALL: read/write pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-022 SHALL: word order out equals order of accepted ready cycles (FIFO order).

Reset
REQ-023 SHALL: reset=0 asynchronously forces pointers=0, occupancy=0, overflow=0, valid=0, full=0, A..D=0000.
REQ-024 SHALL: reset mid-operation discards all stored words; no word issued before reset appears after release.
REQ-025 SHALL: first push accepted on the first rising edge with reset=1 and ready=1.

Structure
REQ-026 SHALL: shared package holds the 16-entry decode table constant, the default DEPTH, and occupancy-state encoding (EMPTY, PARTIAL, FULL).
REQ-027 SHALL: one sub-module, Fila (synchronous FIFO, width 4, depth DEPTH, push/pop/full/empty); Decodificador holds the decode table and overflow flag.

Verification
REQ-028 SHALL: reset release, code 0x5 with ready for 1 cycle -> next cycle valid=1, ABCD=0000; ack -> valid=0.
REQ-029 SHALL: all 16 codes 0x0..0xF pushed with ack held 1 -> outputs 3,4,B,9,6,0,E,8,D,2,F,7,1,A,C,5 in order, each 1 cycle after its input.
REQ-030 SHALL: codes 0xC,0x1,0x8,0x3 with ack=0 -> full=1; fifth code 0x0 -> overflow=1, dropped; drain gives 1,4,D,9.
REQ-031 SHALL: FIFO full, ready=1 code 0xA with ack=1 -> full stays 1, head advances, 0xF (decode of 0xA) at tail, overflow stays 0.
REQ-032 SHALL: 3 words stored, reset=0 for half a cycle mid-clock -> valid, full, overflow, ABCD all 0 immediately, before next edge.
REQ-033 SHALL: ack=1 with FIFO empty for 5 cycles, then one push of 0x7 -> ABCD=1000 valid=1; occupancy never negative.

Source files
------------

// File: rtl/decodificador_pkg.sv
// Shared definitions for the decoder block: decode table, default FIFO depth
// and the occupancy-state encoding used by the FIFO controller.
package decodificador_pkg;

  // Default number of FIFO entries (power of two, 2..16).
  localparam int DEFAULT_DEPTH = 4;

  // Decode table: the data word for code c sits at bits [4*c +: 4].
  // Listed from code F down to code 0. This is the exact inverse of the
  // 4-bit encoder, so every code maps to a unique data word.
  localparam logic [63:0] DECODE_TABLE = {
    4'h5, 4'hC, 4'hA, 4'h1,   // F E D C
    4'h7, 4'hF, 4'h2, 4'hD,   // B A 9 8
    4'h8, 4'hE, 4'h0, 4'h6,   // 7 6 5 4
    4'h9, 4'hB, 4'h4, 4'h3    // 3 2 1 0
  };

  // Occupancy states of the FIFO.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // Table lookup: received code word -> decoded data word.
  function automatic logic [3:0] decode_word(input logic [3:0] code);
    return DECODE_TABLE[{code, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/decodificador_fila.sv
// Fila: synchronous FIFO with an explicit occupancy FSM.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored. Head data is read combinationally
// so a word written on one edge is visible right after that edge.
module fila
  import decodificador_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  occ_state_e       state_q, state_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (state_q != OCC_EMPTY);
  assign do_push = push_i && ((state_q != OCC_FULL) || do_pop);

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers, occupancy counter and state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= OCC_EMPTY;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Next occupancy count and occupancy-state transitions.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      OCC_EMPTY: begin
        if (do_push) state_d = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (do_push && !do_pop && (count_q == DEPTH_C - (AW+1)'(1))) begin
          state_d = OCC_FULL;
        end else if (do_pop && !do_push && (count_q == (AW+1)'(1))) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (do_pop && !do_push) state_d = OCC_PARTIAL;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (state_q == OCC_FULL);
  assign empty_o = (state_q == OCC_EMPTY);

endmodule

// File: rtl/decodificador.sv
// Decodificador: decodes received 4-bit code words through the shared table
// and queues the data words in a FIFO. Words arriving while the FIFO is full
// (with no simultaneous pop) are dropped and flagged by a sticky overflow bit.
module decodificador
  import decodificador_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic S0,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  input  logic ready,
  input  logic ack,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic valid,
  output logic full,
  output logic overflow
);

  logic [3:0] code_w;
  logic [3:0] data_w;
  logic [3:0] head_w;
  logic       empty_w;
  logic       overflow_q;
  logic       drop_w;

  assign code_w = {S0, S1, S2, S3};
  assign data_w = decode_word(code_w);

  fila #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fila (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ready),
    .data_i  (data_w),
    .pop_i   (ack),
    .data_o  (head_w),
    .full_o  (full),
    .empty_o (empty_w)
  );

  // A word is lost only when the FIFO is full and nothing leaves this cycle.
  assign drop_w = ready && full && !ack;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop_w) begin
      overflow_q <= 1'b1;
    end
  end

  assign valid        = !empty_w;
  assign {A, B, C, D} = valid ? head_w : 4'b0000;
  assign overflow     = overflow_q;

endmodule
